// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the unified-memory port arbiter.
//   arbState_t : arbiter FSM states (3-bit encoding)
//   arbSide_t  : requester identifiers (I = fetch, D = memory stage)
package mem_port_arbiter_pkg;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int STREAK_W = 4;   // holds MAX_D_STREAK up to 15
  localparam int TIMER_W  = 8;   // holds TIMEOUT up to 255

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_BUSY_I = 3'd1,
    ARB_BUSY_D = 3'd2,
    ARB_DONE_I = 3'd3,
    ARB_DONE_D = 3'd4
  } arbState_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } arbSide_t;

  function automatic logic isBusyState(input arbState_t s);
    return (s == ARB_BUSY_I) || (s == ARB_BUSY_D);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_streak_counter.sv
// Saturating count of consecutive D-side grants made while a fetch is waiting.
//   clk, rst : clock, asynchronous active-low reset
//   inc      : count one more D grant (ignored once saturated)
//   clr      : restart the streak (wins over inc)
//   sat      : streak has reached MAX; the next grant must go to the fetch side
module mem_port_arbiter_streak_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [STREAK_W-1:0] countReg;

  assign sat = (countReg >= STREAK_W'(MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      countReg <= '0;
    end else if (clr) begin
      countReg <= '0;
    end else if (inc && !sat) begin
      countReg <= countReg + STREAK_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (I) and the
// data memory stage (D). D has priority, but after MAX_D_STREAK consecutive
// D grants with a fetch waiting, the fetch is served. An access that sees no
// mem_done for TIMEOUT BUSY cycles is aborted with a one-cycle err pulse.
//   clk, rst                       : clock, asynchronous active-low reset
//   i_req/i_addr/i_rdata/i_done    : fetch read port, i_stall = i_req & ~i_done
//   d_req/d_wr/d_addr/d_wdata      : data port request
//   d_rdata/d_done/d_stall         : data port response and stall
//   mem_en/mem_wr/mem_addr/mem_wdata : memory command (registered)
//   mem_rdata/mem_done             : memory response
//   err                            : one-cycle pulse on access timeout
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              err
);

  arbState_t           stateReg;
  logic [TIMER_W-1:0]  timerReg;
  logic                memEnReg, memWrReg, iDoneReg, dDoneReg;
  logic [ADDR_W-1:0]   memAddrReg;
  logic [DATA_W-1:0]   memWdataReg, iRdataReg, dRdataReg;

  logic isIdle, grantD, grantI, streakSat, streakInc, streakClr, timeoutHit;

  assign isIdle = (stateReg == ARB_IDLE);
  // D wins a tie unless it has already starved a waiting fetch long enough.
  assign grantD = isIdle && d_req && (!i_req || !streakSat);
  assign grantI = isIdle && i_req && !grantD;

  assign streakInc = grantD && i_req;
  assign streakClr = grantI || (isIdle && !i_req);

  // timerReg counts completed BUSY cycles; the abort cycle is the one where
  // TIMEOUT cycles have already elapsed and the memory still has not answered.
  assign timeoutHit = isBusyState(stateReg) && !mem_done &&
                      (timerReg == TIMER_W'(TIMEOUT));

  mem_port_arbiter_streak_counter #(
    .MAX (MAX_D_STREAK)
  ) uStreak (
    .clk (clk),
    .rst (rst),
    .inc (streakInc),
    .clr (streakClr),
    .sat (streakSat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg    <= ARB_IDLE;
      timerReg    <= '0;
      memEnReg    <= 1'b0;
      memWrReg    <= 1'b0;
      memAddrReg  <= '0;
      memWdataReg <= '0;
      iRdataReg   <= '0;
      dRdataReg   <= '0;
      iDoneReg    <= 1'b0;
      dDoneReg    <= 1'b0;
    end else begin
      memEnReg <= 1'b0;
      iDoneReg <= 1'b0;
      dDoneReg <= 1'b0;
      case (stateReg)
        ARB_IDLE: begin
          if (grantD) begin
            stateReg    <= ARB_BUSY_D;
            memEnReg    <= 1'b1;
            memWrReg    <= d_wr;
            memAddrReg  <= d_addr;
            memWdataReg <= d_wdata;
            timerReg    <= '0;
          end else if (grantI) begin
            stateReg   <= ARB_BUSY_I;
            memEnReg   <= 1'b1;
            memWrReg   <= 1'b0;
            memAddrReg <= i_addr;
            timerReg   <= '0;
          end
        end
        ARB_BUSY_I: begin
          if (mem_done) begin
            iRdataReg <= mem_rdata;
            iDoneReg  <= 1'b1;
            stateReg  <= ARB_DONE_I;
          end else if (timeoutHit) begin
            iRdataReg <= '0;
            iDoneReg  <= 1'b1;
            stateReg  <= ARB_DONE_I;
          end else begin
            timerReg <= timerReg + TIMER_W'(1);
          end
        end
        ARB_BUSY_D: begin
          if (mem_done) begin
            // Writes leave the previous read data visible.
            if (!memWrReg) dRdataReg <= mem_rdata;
            dDoneReg <= 1'b1;
            stateReg <= ARB_DONE_D;
          end else if (timeoutHit) begin
            dRdataReg <= '0;
            dDoneReg  <= 1'b1;
            stateReg  <= ARB_DONE_D;
          end else begin
            timerReg <= timerReg + TIMER_W'(1);
          end
        end
        // Always pass through IDLE so a new grant samples fresh requests.
        ARB_DONE_I, ARB_DONE_D: stateReg <= ARB_IDLE;
        default:                stateReg <= ARB_IDLE;
      endcase
    end
  end

  assign mem_en    = memEnReg;
  assign mem_wr    = memWrReg;
  assign mem_addr  = memAddrReg;
  assign mem_wdata = memWdataReg;
  assign i_rdata   = iRdataReg;
  assign d_rdata   = dRdataReg;
  assign i_done    = iDoneReg;
  assign d_done    = dDoneReg;
  assign i_stall   = i_req && !iDoneReg;
  assign d_stall   = d_req && !dDoneReg;
  assign err       = timeoutHit;

endmodule
